// File: rtl/mux_2to1.sv
// 2:1 word multiplexer built from gate primitives, plus a load-enabled,
// async-reset registered copy of the result for pipeline boundaries.
`timescale 1ns/10ps
module mux_2to1 #(
  parameter int WIDTH    = 64,
  parameter int GATE_DLY = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  wire             sel_n;
  wire [WIDTH-1:0] and0;
  wire [WIDTH-1:0] and1;
  logic [WIDTH-1:0] out_d;

  // One inverter drives every bit slice, so sel-to-out is three gate delays.
  not #(GATE_DLY) u_sel_inv (sel_n, sel);

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    and #(GATE_DLY) u_and0 (and0[k], i0[k], sel_n);
    and #(GATE_DLY) u_and1 (and1[k], i1[k], sel);
    or  #(GATE_DLY) u_or   (out[k], and0[k], and1[k]);
  end

  always_comb begin
    out_d = out_q;
    if (en) out_d = out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: stimulus pushes expected values into a
// scoreboard queue, a monitor pops and compares on each sample strobe.
`timescale 1ns/10ps
module tb_mux_2to1;
  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic         sel;
  logic         en;
  logic [W-1:0] out;
  logic [W-1:0] out_q;

  mux_2to1 #(.WIDTH(W), .GATE_DLY(50)) dut (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .sel(sel), .en(en),
    .out(out), .out_q(out_q)
  );

  // clock/reset block: 400ns period leaves room for the 150ns gate settle
  initial begin
    clk = 1'b0;
    forever #200 clk = ~clk;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit           which_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  event         sample_ev;

  initial begin : monitor
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    bit           which;
    string        nm;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        which = which_q.pop_front();
        nm    = name_q.pop_front();
        act_v = which ? out_q : out;
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h at %0t", nm, act_v, exp_v, $time);
        end
      end
    end
  end

  // driver tasks
  task automatic expect_now(input bit which, input logic [W-1:0] exp_v, input string nm);
    exp_q.push_back(exp_v);
    which_q.push_back(which);
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic e);
    @(negedge clk);
    i0 = a; i1 = b; sel = s; en = e;
  endtask

  // inputs are applied at negedge; 180ns later is settled and before posedge
  task automatic settle();
    #180;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #20;
  endtask

  initial begin : stim
    logic [W-1:0] one_hot;
    rst_n = 1'b0; i0 = '0; i1 = '0; sel = 1'b0; en = 1'b0;
    #100;
    expect_now(1'b1, 64'h0, "reset_out_q");

    // basic select in both directions, still under reset
    drive(64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
    settle();
    expect_now(1'b0, 64'h0000_0000_0000_1000, "sel0_out");
    drive(64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
    settle();
    expect_now(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, "sel1_out");

    // equal inputs: result independent of sel at every settled point
    drive(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0);
    #190;
    for (int t = 0; t < 8; t++) begin
      sel = ~sel;
      #190;
      expect_now(1'b0, 64'hA5A5_A5A5_A5A5_A5A5, "eq_toggle_out");
      #9;
    end

    // walking one on i1, sel=1 then sel=0
    for (int s = 1; s >= 0; s--) begin
      for (int b = 0; b < W; b++) begin
        one_hot = '0;
        one_hot[b] = 1'b1;
        drive('0, one_hot, s[0], 1'b0);
        settle();
        expect_now(1'b0, s[0] ? one_hot : 64'h0, s[0] ? "walk_sel1" : "walk_sel0");
      end
    end

    // reset held with en=1: out_q stays zero while out follows inputs
    for (int c = 0; c < 3; c++) begin
      drive(64'h11 * (c + 1), 64'h0F0F, 1'b0, 1'b1);
      settle();
      expect_now(1'b0, 64'h11 * (c + 1), "rst_out_follows");
      after_edge();
      expect_now(1'b1, 64'h0, "rst_out_q_zero");
    end

    // release reset, first capture on the next edge
    @(negedge clk);
    rst_n = 1'b1; i0 = '0; i1 = 64'h4; sel = 1'b1; en = 1'b1;
    after_edge();
    expect_now(1'b1, 64'h4, "release_capture");

    // load enable holds the previous capture
    drive(64'h0, 64'h1234, 1'b1, 1'b1);
    after_edge();
    expect_now(1'b1, 64'h1234, "en_capture");
    drive(64'h0, 64'hDEAD, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      after_edge();
      expect_now(1'b1, 64'h1234, "en0_hold");
    end
    expect_now(1'b0, 64'hDEAD, "en0_out_live");
    drive(64'h0, 64'hDEAD, 1'b1, 1'b1);
    after_edge();
    expect_now(1'b1, 64'hDEAD, "en1_reload");

    // asynchronous reset between edges
    drive(64'hFF, 64'h0, 1'b0, 1'b1);
    after_edge();
    expect_now(1'b1, 64'hFF, "pre_async_ff");
    #50;
    rst_n = 1'b0;
    #10;
    expect_now(1'b1, 64'h0, "async_clear");
    expect_now(1'b0, 64'hFF, "async_out_live");
    after_edge();
    expect_now(1'b1, 64'h0, "async_hold_low");
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    expect_now(1'b1, 64'hFF, "post_async_capture");

    #10;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
